// File: rtl/epcs_flash_seq.sv
// -----------------------------------------------------------------------------
// epcs_flash_seq
//
// Command sequencer in front of the EPCS/ASMI parallel flash IP. The host side
// issues one command at a time: read byte, write byte, or sector erase. The
// sequencer raises the matching ASMI enable, fires a one-cycle strobe, watches
// busy / data_valid / illegal flags and returns exactly one response per
// accepted command.
//
// Ports
//   clkin               system clock (ASMI clkin is driven from the same net)
//   reset               synchronous, active-low reset
//   cmd_valid/ready     host command handshake (ready only in IDLE)
//   cmd_op              0=read byte, 1=write byte, 2=sector erase, 3=reserved
//   cmd_addr/cmd_wdata  flash address and write data, latched on accept
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           read data, valid with rsp_valid (0 if none captured)
//   rsp_err             {timeout, no_start, illegal}; all zero = success
//   asmi_*              ASMI controls (outputs) and status (inputs)
// -----------------------------------------------------------------------------
module epcs_flash_seq #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned RISE_MAX    = 16,
    parameter int unsigned TIMEOUT_CYC = 400000000,
    parameter int unsigned RST_CYC     = 8,
    parameter bit          EN4B        = 1'b1
) (
    input  logic              clkin,
    input  logic              reset,
    // host side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic [2:0]        rsp_err,
    // ASMI side
    output logic              asmi_read,
    output logic              asmi_rden,
    output logic [ADDR_W-1:0] asmi_addr,
    output logic              asmi_write,
    output logic [7:0]        asmi_datain,
    output logic              asmi_sector_erase,
    output logic              asmi_wren,
    output logic              asmi_en4b_addr,
    output logic              asmi_reset,
    output logic [2:0]        asmi_sce,
    input  logic [7:0]        asmi_dataout,
    input  logic              asmi_busy,
    input  logic              asmi_data_valid,
    input  logic              asmi_illegal_write,
    input  logic              asmi_illegal_erase
);

    // Counter widths: clog2 of each limit holds the terminal value limit-1.
    localparam int RISE_W = (RISE_MAX    > 1) ? $clog2(RISE_MAX)    : 1;
    localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RST_W  = (RST_CYC     > 1) ? $clog2(RST_CYC)     : 1;

    localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(RISE_MAX - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYC - 1);

    // rsp_err bit positions
    localparam int ERR_ILLEGAL  = 0;
    localparam int ERR_NO_START = 1;
    localparam int ERR_TIMEOUT  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT_RISE,
        S_WAIT_DONE,
        S_RESP,
        S_ABORT
    } state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ERASE = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    state_e              state_q,     state_d;
    op_e                 op_q,        op_d;
    logic [RISE_W-1:0]   rise_cnt_q,  rise_cnt_d;
    logic [TO_W-1:0]     to_cnt_q,    to_cnt_d;
    logic [RST_W-1:0]    rst_cnt_q,   rst_cnt_d;
    logic                captured_q,  captured_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_rdata_q, rsp_rdata_d;
    logic [2:0]          rsp_err_q,   rsp_err_d;
    logic                read_q,      read_d;
    logic                write_q,     write_d;
    logic                erase_q,     erase_d;
    logic                rden_q,      rden_d;
    logic                wren_q,      wren_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [7:0]          datain_q,    datain_d;
    logic                areset_q,    areset_d;

    logic                enable_phase;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        rise_cnt_d  = rise_cnt_q;
        to_cnt_d    = to_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        captured_d  = captured_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        addr_d      = addr_q;
        datain_d    = datain_q;

        // Read data may arrive before or after busy rises; only the first
        // data_valid of a read command is kept.
        if ((state_q == S_WAIT_RISE || state_q == S_WAIT_DONE) &&
            op_q == OP_READ && asmi_data_valid && !captured_q) begin
            rsp_rdata_d = asmi_dataout;
            captured_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = op_e'(cmd_op);
                    addr_d      = cmd_addr;
                    datain_d    = cmd_wdata;
                    rsp_rdata_d = 8'h00;
                    rsp_err_d   = 3'b000;
                    captured_d  = 1'b0;
                    if (op_e'(cmd_op) == OP_RSVD) begin
                        // Reserved opcode: answer at once, never touch ASMI.
                        rsp_err_d[ERR_ILLEGAL] = 1'b1;
                        state_d                = S_RESP;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end

            S_SETUP: begin
                state_d = S_STROBE;
            end

            S_STROBE: begin
                rise_cnt_d = '0;
                state_d    = S_WAIT_RISE;
            end

            S_WAIT_RISE: begin
                // A busy seen on the terminal count still counts as a start.
                if (asmi_busy) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_DONE;
                end else if (rise_cnt_q == RISE_LAST) begin
                    rsp_err_d[ERR_NO_START] = 1'b1;
                    state_d                 = S_RESP;
                end else begin
                    rise_cnt_d = rise_cnt_q + RISE_W'(1);
                end
            end

            S_WAIT_DONE: begin
                if (asmi_illegal_write || asmi_illegal_erase) begin
                    rsp_err_d[ERR_ILLEGAL] = 1'b1;
                end
                if (!asmi_busy) begin
                    state_d = S_RESP;
                end else if (to_cnt_q == TO_LAST) begin
                    rsp_err_d[ERR_TIMEOUT] = 1'b1;
                    rst_cnt_d              = '0;
                    state_d                = S_ABORT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            S_ABORT: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RESP;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            S_RESP: begin
                // The error code is only meaningful alongside rsp_valid.
                rsp_err_d = 3'b000;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state so that, once registered,
        // they line up exactly with the state they belong to.
        enable_phase = (state_d == S_SETUP)     || (state_d == S_STROBE) ||
                       (state_d == S_WAIT_RISE) || (state_d == S_WAIT_DONE);

        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        areset_d    = (state_d == S_ABORT);
        rden_d      = enable_phase && (op_d == OP_READ);
        wren_d      = enable_phase && (op_d != OP_READ);
        read_d      = (state_d == S_STROBE) && (op_d == OP_READ);
        write_d     = (state_d == S_STROBE) && (op_d == OP_WRITE);
        erase_d     = (state_d == S_STROBE) && (op_d == OP_ERASE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clkin) begin
        if (!reset) begin
            // Reset aborts any command without a response and holds the ASMI
            // in reset; asmi_reset drops on the first cycle after release.
            state_q     <= S_IDLE;
            op_q        <= OP_READ;
            rise_cnt_q  <= '0;
            to_cnt_q    <= '0;
            rst_cnt_q   <= '0;
            captured_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 3'b000;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            erase_q     <= 1'b0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            datain_q    <= 8'h00;
            areset_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rise_cnt_q  <= rise_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            captured_q  <= captured_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            read_q      <= read_d;
            write_q     <= write_d;
            erase_q     <= erase_d;
            rden_q      <= rden_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            datain_q    <= datain_d;
            areset_q    <= areset_d;
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign rsp_err           = rsp_err_q;
    assign asmi_read         = read_q;
    assign asmi_write        = write_q;
    assign asmi_sector_erase = erase_q;
    assign asmi_rden         = rden_q;
    assign asmi_wren         = wren_q;
    assign asmi_addr         = addr_q;
    assign asmi_datain       = datain_q;
    assign asmi_reset        = areset_q;

    // Static straps.
    assign asmi_en4b_addr    = EN4B;
    assign asmi_sce          = 3'b000;

endmodule

// File: tb/tb_epcs_flash_seq.sv
// -----------------------------------------------------------------------------
// tb_epcs_flash_seq
//
// Self-checking bench for epcs_flash_seq. A small ASMI responder, driven from
// per-command scenario records, plays the flash side. Directed records carry
// hand-derived expectations; random records get theirs from a reference model
// that works on timing windows relative to the strobe.
// -----------------------------------------------------------------------------
module tb_epcs_flash_seq;

    localparam int T_RISE = 16;
    localparam int T_TO   = 100;
    localparam int T_RST  = 8;

    logic        clkin = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [2:0]  rsp_err;
    logic        asmi_read;
    logic        asmi_rden;
    logic [31:0] asmi_addr;
    logic        asmi_write;
    logic [7:0]  asmi_datain;
    logic        asmi_sector_erase;
    logic        asmi_wren;
    logic        asmi_en4b_addr;
    logic        asmi_reset;
    logic [2:0]  asmi_sce;
    logic [7:0]  asmi_dataout;
    logic        asmi_busy;
    logic        asmi_data_valid;
    logic        asmi_illegal_write;
    logic        asmi_illegal_erase;

    int n_vec = 0;
    int n_bad = 0;

    epcs_flash_seq #(
        .ADDR_W      (32),
        .RISE_MAX    (T_RISE),
        .TIMEOUT_CYC (T_TO),
        .RST_CYC     (T_RST),
        .EN4B        (1'b1)
    ) dut (
        .clkin              (clkin),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .asmi_read          (asmi_read),
        .asmi_rden          (asmi_rden),
        .asmi_addr          (asmi_addr),
        .asmi_write         (asmi_write),
        .asmi_datain        (asmi_datain),
        .asmi_sector_erase  (asmi_sector_erase),
        .asmi_wren          (asmi_wren),
        .asmi_en4b_addr     (asmi_en4b_addr),
        .asmi_reset         (asmi_reset),
        .asmi_sce           (asmi_sce),
        .asmi_dataout       (asmi_dataout),
        .asmi_busy          (asmi_busy),
        .asmi_data_valid    (asmi_data_valid),
        .asmi_illegal_write (asmi_illegal_write),
        .asmi_illegal_erase (asmi_illegal_erase)
    );

    always #5 clkin = ~clkin;

    // One command scenario. Times d/dv1/dv2/ill_t count cycles after the
    // cycle in which the strobe is visible; busy is high for t in [d, d+len).
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [7:0]  wdata;
        int          d;
        int          len;
        int          dv1;
        int          dv2;
        logic [7:0]  dvdata;
        int          ill_t;
        bit          ill_wr;
        logic [2:0]  exp_err;
        logic [7:0]  exp_rdata;
        int          exp_lat;   // cycle of rsp_valid, accept cycle = 0
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr,
                                input logic [7:0] wdata, input int d, input int len,
                                input int dv1, input int dv2, input logic [7:0] dvdata,
                                input int ill_t, input bit ill_wr,
                                input logic [2:0] exp_err, input logic [7:0] exp_rdata,
                                input int exp_lat);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.d = d; v.len = len;
        v.dv1 = dv1; v.dv2 = dv2; v.dvdata = dvdata; v.ill_t = ill_t;
        v.ill_wr = ill_wr; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        v.exp_lat = exp_lat;
        return v;
    endfunction

    // Reference model. The command passes SETUP and STROBE (strobe at cycle 2),
    // then WAIT_RISE covers t = 1..RISE_MAX until busy is seen, WAIT_DONE runs
    // from the cycle after busy rises to the first idle sample (or the
    // timeout), and the response follows in the next cycle.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   last;
        int   ill_lo;
        int   ill_hi;
        r = v;
        r.exp_err   = 3'b000;
        r.exp_rdata = 8'h00;
        if (v.op == 2'd3) begin
            r.exp_err = 3'b001;
            r.exp_lat = 1;
            return r;
        end
        if (v.len == 0 || v.d > T_RISE) begin
            r.exp_err[1] = 1'b1;
            last         = T_RISE;
            r.exp_lat    = T_RISE + 3;
            ill_lo       = 1;
            ill_hi       = 0;
        end else if (v.len > T_TO) begin
            r.exp_err[2] = 1'b1;
            last         = v.d + T_TO;
            r.exp_lat    = 2 + last + 1 + T_RST;
            ill_lo       = v.d + 1;
            ill_hi       = last;
        end else begin
            last         = v.d + v.len;
            r.exp_lat    = 2 + last + 1;
            ill_lo       = v.d + 1;
            ill_hi       = last;
        end
        if (v.ill_t >= ill_lo && v.ill_t <= ill_hi) r.exp_err[0] = 1'b1;
        if (v.op == 2'd0) begin
            if (v.dv1 >= 1 && v.dv1 <= last)      r.exp_rdata = v.dvdata;
            else if (v.dv2 >= 1 && v.dv2 <= last) r.exp_rdata = ~v.dvdata;
        end
        return r;
    endfunction

    task automatic idle_inputs();
        cmd_valid          = 1'b0;
        cmd_op             = 2'd0;
        cmd_addr           = 32'h0;
        cmd_wdata          = 8'h00;
        asmi_dataout       = 8'h00;
        asmi_busy          = 1'b0;
        asmi_data_valid    = 1'b0;
        asmi_illegal_write = 1'b0;
        asmi_illegal_erase = 1'b0;
    endtask

    // Issue one command and play the flash side until well after the
    // expected response, then compare everything observed.
    task automatic run_txn(input vec_t v, input string tag);
        int         c;
        int         s;
        int         t;
        int         wait_cyc;
        int         rsp_cyc;
        int         n_rsp;
        int         n_strobe;
        int         rst_cyc;
        logic [2:0] got_err;
        logic [7:0] got_rdata;
        logic [2:0] kind;
        logic [31:0] addr_at;
        logic [7:0] din_at;
        logic       en_at;
        logic       en_rsp;
        bit         host_hold;

        s = -1; rsp_cyc = -1; n_rsp = 0; n_strobe = 0; rst_cyc = 0;
        got_err = 3'b000; got_rdata = 8'h00; kind = 3'b000; addr_at = 32'h0;
        din_at = 8'h00; en_at = 1'b0; en_rsp = 1'b1;

        wait_cyc = 0;
        while (cmd_ready !== 1'b1 && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        check({tag, " ready"}, cmd_ready, 1'b1);

        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        host_hold = 1'b1;
        c = 0;
        while (c < v.exp_lat + 12) begin
            tick();
            c++;
            if (asmi_read || asmi_write || asmi_sector_erase) begin
                n_strobe++;
                if (s < 0) begin
                    s       = c;
                    kind    = {asmi_sector_erase, asmi_write, asmi_read};
                    addr_at = asmi_addr;
                    din_at  = asmi_datain;
                    en_at   = (v.op == 2'd0) ? asmi_rden : asmi_wren;
                end
            end
            if (asmi_reset) rst_cyc++;
            if (rsp_valid) begin
                n_rsp++;
                host_hold = 1'b0;
                if (rsp_cyc < 0) begin
                    rsp_cyc   = c;
                    got_err   = rsp_err;
                    got_rdata = rsp_rdata;
                    en_rsp    = asmi_rden | asmi_wren;
                end
            end
            // The host keeps cmd_valid up with junk fields until the response;
            // the sequencer must ignore it outside IDLE.
            cmd_valid = host_hold;
            cmd_op    = 2'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = 8'($urandom);
            // Flash responder.
            t = (s >= 0) ? (c - s) : -1;
            asmi_busy          = (t >= 0) && (t >= v.d) && (t < v.d + v.len);
            asmi_data_valid    = (t >= 0) && (t == v.dv1 || t == v.dv2);
            asmi_dataout       = (t >= 0 && t == v.dv1) ? v.dvdata :
                                 (t >= 0 && t == v.dv2) ? ~v.dvdata : 8'($urandom);
            asmi_illegal_write = (t >= 0) && (t == v.ill_t) && v.ill_wr;
            asmi_illegal_erase = (t >= 0) && (t == v.ill_t) && !v.ill_wr;
        end
        idle_inputs();

        check({tag, " rsp_count"}, n_rsp, 1);
        check({tag, " rsp_cycle"}, rsp_cyc, v.exp_lat);
        check({tag, " rsp_err"}, got_err, v.exp_err);
        check({tag, " rsp_rdata"}, got_rdata, v.exp_rdata);
        check({tag, " strobes"}, n_strobe, (v.op == 2'd3) ? 1'b0 : 1'b1);
        check({tag, " en_at_rsp"}, en_rsp, 1'b0);
        check({tag, " reset_cycles"}, rst_cyc, v.exp_err[2] ? T_RST : 0);
        check({tag, " err_cleared"}, rsp_err, 3'b000);
        if (v.op != 2'd3) begin
            check({tag, " strobe_kind"}, kind, 3'b001 << v.op);
            check({tag, " strobe_addr"}, addr_at, v.addr);
            check({tag, " strobe_enable"}, en_at, 1'b1);
            if (v.op == 2'd1) check({tag, " strobe_datain"}, din_at, v.wdata);
        end
    endtask

    vec_t tbl[17];

    initial begin
        vec_t rv;
        int   r;
        int   mode;
        int   n_rsp;

        idle_inputs();
        reset = 1'b0;

        tbl[0]  = mk(2'd0, 32'h0001_0000, 8'h00,  1,   5,  3, -1, 8'hA5, -1, 0, 3'b000, 8'hA5,   9);
        tbl[1]  = mk(2'd1, 32'h00FF_FFFF, 8'h3C,  2,   4, -1, -1, 8'h00, -1, 0, 3'b000, 8'h00,   9);
        tbl[2]  = mk(2'd2, 32'h0002_0000, 8'h00,  1,   6, -1, -1, 8'h00,  3, 0, 3'b001, 8'h00,  10);
        tbl[3]  = mk(2'd2, 32'h0003_0000, 8'h00, 99,   0, -1, -1, 8'h00, -1, 0, 3'b010, 8'h00,  19);
        tbl[4]  = mk(2'd2, 32'h0004_0000, 8'h00,  1, 105, -1, -1, 8'h00, -1, 0, 3'b100, 8'h00, 112);
        tbl[5]  = mk(2'd3, 32'h0005_0000, 8'h77,  1,   5, -1, -1, 8'h00, -1, 0, 3'b001, 8'h00,   1);
        tbl[6]  = mk(2'd0, 32'h0000_0010, 8'h00,  2,   3, -1, -1, 8'h00, -1, 0, 3'b000, 8'h00,   8);
        tbl[7]  = mk(2'd0, 32'h0000_0020, 8'h00,  1,   5,  2,  4, 8'h11, -1, 0, 3'b000, 8'h11,   9);
        tbl[8]  = mk(2'd1, 32'h0000_0030, 8'h5A, 16,   2, -1, -1, 8'h00, -1, 0, 3'b000, 8'h00,  21);
        tbl[9]  = mk(2'd1, 32'h0000_0040, 8'h5A, 17,   2, -1, -1, 8'h00, -1, 0, 3'b010, 8'h00,  19);
        tbl[10] = mk(2'd2, 32'h0000_0050, 8'h00,  1, 100, -1, -1, 8'h00, -1, 0, 3'b000, 8'h00, 104);
        tbl[11] = mk(2'd2, 32'h0000_0060, 8'h00,  1, 101, -1, -1, 8'h00, -1, 0, 3'b100, 8'h00, 112);
        tbl[12] = mk(2'd1, 32'h0000_0070, 8'h01,  3,   4, -1, -1, 8'h00,  3, 1, 3'b000, 8'h00,  10);
        tbl[13] = mk(2'd1, 32'h0000_0080, 8'h02,  3,   4, -1, -1, 8'h00,  7, 1, 3'b001, 8'h00,  10);
        tbl[14] = mk(2'd0, 32'h0000_0090, 8'h00,  1,   2,  4, -1, 8'hC3, -1, 0, 3'b000, 8'h00,   6);
        tbl[15] = mk(2'd0, 32'h0000_00A0, 8'h00,  1,   2,  3, -1, 8'h3C, -1, 0, 3'b000, 8'h3C,   6);
        tbl[16] = mk(2'd0, 32'h0000_00B0, 8'h00, 50,   0,  5, -1, 8'h99, -1, 0, 3'b010, 8'h99,  19);

        // Reset values.
        repeat (3) tick();
        check("rst cmd_ready", cmd_ready, 1'b0);
        check("rst asmi_reset", asmi_reset, 1'b1);
        check("rst strobes", {asmi_read, asmi_write, asmi_sector_erase}, 3'b000);
        check("rst enables", {asmi_rden, asmi_wren}, 2'b00);
        check("rst asmi_addr", asmi_addr, 32'h0);
        check("rst asmi_datain", asmi_datain, 8'h00);
        check("rst rsp", {rsp_valid, rsp_err, rsp_rdata}, 12'h000);
        check("static en4b", asmi_en4b_addr, 1'b1);
        check("static sce", asmi_sce, 3'b000);
        reset = 1'b1;
        tick();
        check("release cmd_ready", cmd_ready, 1'b1);
        check("release asmi_reset", asmi_reset, 1'b0);

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            run_txn(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset during WAIT_DONE: no response, ASMI re-reset, ready after release.
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_addr  = 32'h00C0_0000;
        tick();
        cmd_valid = 1'b0;
        asmi_busy = 1'b1;
        n_rsp = 0;
        repeat (10) begin
            tick();
            if (rsp_valid) n_rsp++;
        end
        check("midop rden", asmi_rden, 1'b1);
        reset = 1'b0;
        tick();
        check("midop asmi_reset", asmi_reset, 1'b1);
        check("midop rden_off", asmi_rden, 1'b0);
        check("midop cmd_ready", cmd_ready, 1'b0);
        if (rsp_valid) n_rsp++;
        tick();
        if (rsp_valid) n_rsp++;
        reset     = 1'b1;
        asmi_busy = 1'b0;
        tick();
        check("midop release ready", cmd_ready, 1'b1);
        check("midop release asmi_reset", asmi_reset, 1'b0);
        repeat (20) begin
            tick();
            if (rsp_valid) n_rsp++;
        end
        check("midop no_rsp", n_rsp, 0);

        // Random scenarios against the reference model.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            rv.op     = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            rv.addr   = $urandom;
            rv.wdata  = 8'($urandom);
            rv.d      = $urandom_range(1, 18);
            mode      = $urandom_range(0, 7);
            rv.len    = (mode == 0) ? 0 : (mode == 1) ? $urandom_range(99, 102)
                                                     : $urandom_range(1, 8);
            rv.dv1    = ($urandom_range(0, 3) == 0) ? -1
                                                    : $urandom_range(1, rv.d + rv.len + 2);
            rv.dv2    = (rv.dv1 < 0) ? -1 : rv.dv1 + $urandom_range(1, 3);
            rv.dvdata = 8'($urandom);
            rv.ill_t  = ($urandom_range(0, 1) == 0) ? -1
                                                    : $urandom_range(rv.d, rv.d + rv.len + 1);
            rv.ill_wr = 1'($urandom);
            rv = model(rv);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
